operand_stepper: RTL and testbench

//   Upstream operand source for the specialised-multiplier/7-seg stage.

---
 rtl/operand_stepper.sv | 199 +++++++++++++++++++
 tb/tb_operand_stepper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stepper.sv
// -----------------------------------------------------------------------------
// operand_stepper
//
// Purpose
//   Turns two noisy, active-low push-buttons (increment / decrement) into a
//   registered 4-bit operand in the range 0..MAX_VAL. The operand feeds the
//   multiplier / 7-segment stage downstream.
//
//   Each button passes through:
//     1. a 2-flop synchroniser,
//     2. a debouncer, which accepts a new level only after it has been stable
//        for DEBOUNCE_CYCLES clocks,
//     3. a press detector, which fires on the accepted 1->0 transition.
//
//   The operand then steps with wrap-around. The step priority is:
//     clr > simultaneous inc+dec (cancel) > inc > dec.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   btn_inc_n   in   1  raw increment button, active-low, asynchronous to clk
//   btn_dec_n   in   1  raw decrement button, active-low, asynchronous to clk
//   clr         in   1  synchronous clear, active-high
//   operand     out  4  current operand, registered, always in 0..MAX_VAL
//   step_pulse  out  1  one-cycle strobe; high in the first cycle a new
//                       operand value is visible
//
// Configuration
//   AUTO_REPEAT_EN  When defined, a button held alone generates a step after
//                   REPEAT_DELAY clocks, then one step every REPEAT_PERIOD
//                   clocks. When undefined, the repeat logic is absent and
//                   each accepted press produces exactly one step.
// -----------------------------------------------------------------------------
module operand_stepper #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_VAL         = 8,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc_n,
    input  logic       btn_dec_n,
    input  logic       clr,
    output logic [3:0] operand,
    output logic       step_pulse
);

    // Reject out-of-range configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || MAX_VAL < 1 || MAX_VAL > 15 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("operand_stepper: parameter out of range");
    end

    localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]        MAX_OP  = 4'(MAX_VAL);

    // Button index: bit 0 = increment, bit 1 = decrement.
    logic [1:0]             btn_raw_n;
    logic [1:0]             sync1_q, sync2_q;
    logic [1:0]             stable_q, stable_d;
    logic [1:0]             stable_prev_q;
    logic [1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [1:0]             press_evt;
    logic [1:0]             step_req;
    logic [3:0]             operand_q, operand_d;
    logic                   step_pulse_q, step_pulse_d;

    assign btn_raw_n = {btn_dec_n, btn_inc_n};

    // -------------------------------------------------------------------------
    // Debounce.
    // The counter runs only while the synchronised level disagrees with the
    // accepted level. Any return to agreement restarts it, so only an
    // uninterrupted run of DEBOUNCE_CYCLES differing clocks is accepted.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first. A path that leaves a signal unassigned would infer a latch.
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // A press is the accepted 1->0 transition. A release produces nothing.
    assign press_evt = stable_prev_q & ~stable_q;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [1:0][RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic [1:0]             rpt_armed_q, rpt_armed_d;   // first repeat already issued
    logic [1:0]             rpt_evt;
    logic [1:0]             pressed;
    logic                   solo;
    logic [RPT_W-1:0]       rpt_limit;

    assign pressed = ~stable_q;
    assign solo    = pressed[0] ^ pressed[1];

    // The counter holds the number of clocks since the last step (or since
    // acceptance). It fires on reaching the limit and restarts at 1, so the
    // next firing lands exactly REPEAT_PERIOD clocks later.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_evt     = '0;
        rpt_limit   = '0;
        for (int i = 0; i < 2; i++) begin
            rpt_limit = rpt_armed_q[i] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
            if (pressed[i] && solo && !clr) begin
                if (rpt_cnt_q[i] == rpt_limit) begin
                    rpt_evt[i]     = 1'b1;
                    rpt_cnt_d[i]   = RPT_W'(1);
                    rpt_armed_d[i] = 1'b1;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                end
            end else begin
                rpt_cnt_d[i]   = '0;
                rpt_armed_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= '0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end

    assign step_req = press_evt | rpt_evt;
`else
    assign step_req = press_evt;
`endif

    // -------------------------------------------------------------------------
    // Step logic. 4-bit arithmetic with explicit wrap, so the operand never
    // leaves 0..MAX_VAL.
    // -------------------------------------------------------------------------
    always_comb begin
        operand_d    = operand_q;
        step_pulse_d = 1'b0;
        if (clr) begin
            operand_d    = 4'd0;
            step_pulse_d = (operand_q != 4'd0);
        end else if (step_req[0] && step_req[1]) begin
            // Simultaneous inc and dec cancel each other.
            operand_d = operand_q;
        end else if (step_req[0]) begin
            operand_d    = (operand_q == MAX_OP) ? 4'd0 : operand_q + 4'd1;
            step_pulse_d = 1'b1;
        end else if (step_req[1]) begin
            operand_d    = (operand_q == 4'd0) ? MAX_OP : operand_q - 4'd1;
            step_pulse_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its input from before the edge, whatever order the code is in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 2'b11;
            sync2_q       <= 2'b11;
            stable_q      <= 2'b11;
            stable_prev_q <= 2'b11;
            db_cnt_q      <= '0;
            operand_q     <= 4'd0;
            step_pulse_q  <= 1'b0;
        end else begin
            sync1_q       <= btn_raw_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
            operand_q     <= operand_d;
            step_pulse_q  <= step_pulse_d;
        end
    end

    assign operand    = operand_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_operand_stepper.sv
// -----------------------------------------------------------------------------
// tb_operand_stepper
//
// Directed bench for operand_stepper, built with
//   DEBOUNCE_CYCLES=4, MAX_VAL=8, REPEAT_DELAY=20, REPEAT_PERIOD=8.
//
// Timing reference: a raw edge driven just after clock edge 0 moves the
// operand at edge 2 + 4 + 1 = 7.
// -----------------------------------------------------------------------------
module tb_operand_stepper;

    localparam int DB   = 4;
    localparam int MAXV = 8;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int LAT  = 2 + DB + 1;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_inc_n = 1'b1;
    logic       btn_dec_n = 1'b1;
    logic       clr       = 1'b0;
    logic [3:0] operand;
    logic       step_pulse;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    int pulse_base;

    operand_stepper #(
        .DEBOUNCE_CYCLES (DB),
        .MAX_VAL         (MAXV),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_inc_n  (btn_inc_n),
        .btn_dec_n  (btn_dec_n),
        .clr        (clr),
        .operand    (operand),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    // step_pulse lasts one cycle, so sampling it on the falling edge counts
    // each pulse exactly once.
    always @(negedge clk) if (step_pulse === 1'b1) pulse_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean press-and-release of one button.
    task automatic press(input bit dec, input int exp_op, input string tag);
        pulse_base = pulse_cnt;
        if (dec) btn_dec_n = 1'b0; else btn_inc_n = 1'b0;
        tick(LAT);
        check({tag, "_op"}, operand, exp_op);
        check({tag, "_pulse"}, step_pulse, 1);
        btn_inc_n = 1'b1;
        btn_dec_n = 1'b1;
        tick(LAT + 2);
        check({tag, "_npulses"}, pulse_cnt - pulse_base, 1);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
    endtask

    initial begin
        int exp_op;

        // ---- reset state ----
        tick(2);
        check("rst_operand", operand, 0);
        check("rst_pulse", step_pulse, 0);
        rst_n = 1'b1;
        tick(2);

        // ---- clean press: exact latency, single pulse, no step while held ----
        pulse_base = pulse_cnt;
        btn_inc_n  = 1'b0;
        tick(LAT - 1);
        check("lat_before", operand, 0);
        tick(1);
        check("lat_at", operand, 1);
        check("lat_pulse", step_pulse, 1);
        tick(1);
        check("pulse_width", step_pulse, 0);
        tick(10);
        check("held_operand", operand, 1);
        check("held_npulses", pulse_cnt - pulse_base, 1);
        btn_inc_n = 1'b1;
        tick(LAT + 2);

        // ---- bounce: low 2, high 1, then held low -> one step ----
        pulse_base = pulse_cnt;
        btn_inc_n  = 1'b0;
        tick(2);
        btn_inc_n  = 1'b1;
        tick(1);
        btn_inc_n  = 1'b0;
        tick(LAT - 1);
        check("bounce_before", operand, 1);
        tick(1);
        check("bounce_at", operand, 2);
        tick(3);
        btn_inc_n = 1'b1;
        tick(LAT + 2);
        check("bounce_npulses", pulse_cnt - pulse_base, 1);

        // ---- 1-clock glitch on each button -> nothing ----
        pulse_base = pulse_cnt;
        btn_inc_n  = 1'b0;
        tick(1);
        btn_inc_n  = 1'b1;
        tick(12);
        btn_dec_n  = 1'b0;
        tick(1);
        btn_dec_n  = 1'b1;
        tick(12);
        check("glitch_operand", operand, 2);
        check("glitch_npulses", pulse_cnt - pulse_base, 0);

        // ---- clr at nonzero -> 0 with pulse ----
        clr = 1'b1;
        tick(1);
        check("clr2_operand", operand, 0);
        check("clr2_pulse", step_pulse, 1);
        clr = 1'b0;
        tick(1);
        check("clr2_pulse_end", step_pulse, 0);

        // ---- wrap: 9 incs from 0 -> 1..8 then 0; dec from 0 -> 8 ----
        for (int i = 1; i <= MAXV + 1; i++)
            press(1'b0, i % (MAXV + 1), $sformatf("wrap_inc%0d", i));
        press(1'b1, MAXV, "wrap_dec");
        press(1'b1, MAXV - 1, "dec");

        // ---- simultaneous inc+dec cancels ----
        do_clear();
        for (int i = 1; i <= 3; i++) press(1'b0, i, $sformatf("to3_%0d", i));
        pulse_base = pulse_cnt;
        btn_inc_n  = 1'b0;
        btn_dec_n  = 1'b0;
        tick(LAT + 8);
        check("simul_operand", operand, 3);
        check("simul_npulses", pulse_cnt - pulse_base, 0);
        btn_inc_n = 1'b1;
        btn_dec_n = 1'b1;
        tick(LAT + 2);

        // ---- clr at 3 -> 0 with pulse; clr held at 0 -> no pulse ----
        clr = 1'b1;
        tick(1);
        check("clr3_operand", operand, 0);
        check("clr3_pulse", step_pulse, 1);
        tick(1);
        check("clr0_operand", operand, 0);
        check("clr0_pulse", step_pulse, 0);
        clr = 1'b0;
        tick(1);

        // ---- async reset at operand 5, mid-debounce ----
        for (int i = 1; i <= 5; i++) press(1'b0, i, $sformatf("to5_%0d", i));
        btn_inc_n = 1'b0;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_operand", operand, 0);
        check("async_rst_pulse", step_pulse, 0);
        tick(1);
        rst_n = 1'b1;
        // Button still low: debounce must restart from scratch.
        tick(LAT - 1);
        check("rst_discard_before", operand, 0);
        tick(1);
        check("rst_discard_at", operand, 1);
        btn_inc_n = 1'b1;
        tick(LAT + 2);

        // ---- long hold: auto-repeat steps, or exactly one step ----
        do_clear();
        pulse_base = pulse_cnt;
        btn_inc_n  = 1'b0;
        tick(LAT);
        check("hold_accept", operand, 1);
        for (int k = 1; k <= 70; k++) begin
            tick(1);
            exp_op = 1;
`ifdef AUTO_REPEAT_EN
            for (int m = 0; m < 5; m++)
                if (RD + m * RP <= k) exp_op++;
`endif
            check($sformatf("hold_k%0d", k), operand, exp_op);
            // Release early enough that the accepted level drops before +60.
            if (k == 53) btn_inc_n = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        check("hold_npulses", pulse_cnt - pulse_base, 6);
`else
        check("hold_npulses", pulse_cnt - pulse_base, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
